// File: rtl/dkm_pkg.sv
// rtl/dkm_pkg.sv - shared encodings, defaults and counter helper for the eject block
package dkm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FIRE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_CAN    = 2'd1,
        SEL_NICKEL = 2'd2,
        SEL_DIME   = 2'd3
    } sel_t;

    localparam int PULSE_CYCLES_DEF = 4;
    localparam int GAP_CYCLES_DEF   = 2;

    // Returns {overflow, new_count}; a decrement only occurs on a non-zero count.
    function automatic logic [2:0] sat_update(input logic [1:0] cnt,
                                              input logic [1:0] inc,
                                              input logic       dec);
        logic [3:0] sum;
        sum = {2'b00, cnt} + {2'b00, inc} - {3'b000, dec};
        if (sum > 4'd3)
            sat_update = {1'b1, 2'd3};
        else
            sat_update = {1'b0, sum[1:0]};
    endfunction

endpackage

// File: rtl/dkm_eject_timer.sv
// rtl/dkm_eject_timer.sv - 4-bit loadable down-counter shared by pulse and gap phases
module dkm_eject_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule

// File: rtl/dkm_eject.sv
// rtl/dkm_eject.sv - solenoid sequencer for can and coin ejection with pending counters
module dkm_eject
    import dkm_pkg::*;
#(
    parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic DISPENSE,
    input  logic NICKEL_OUT,
    input  logic DIME_OUT,
    input  logic TWO_DIME_OUT,
    output logic CAN_SOL,
    output logic NICKEL_SOL,
    output logic DIME_SOL,
    output logic BUSY,
    output logic OVERRUN
);

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [1:0] can_cnt, nickel_cnt, dime_cnt;
    logic [2:0] can_upd, nickel_upd, dime_upd;
    sel_t       pick;
    logic       any_pending;
    logic       fire_start;
    logic       t_load;
    logic [3:0] t_value;
    logic       t_done;

    dkm_eject_timer u_timer (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (t_load),
        .load_value (t_value),
        .done       (t_done)
    );

    always_comb begin
        any_pending = (can_cnt != 2'd0) || (nickel_cnt != 2'd0) || (dime_cnt != 2'd0);
        if (can_cnt != 2'd0)
            pick = SEL_CAN;
        else if (nickel_cnt != 2'd0)
            pick = SEL_NICKEL;
        else if (dime_cnt != 2'd0)
            pick = SEL_DIME;
        else
            pick = SEL_NONE;
    end

    always_comb begin
        state_nxt  = state;
        fire_start = 1'b0;
        t_load     = 1'b0;
        t_value    = 4'd0;
        case (state)
            ST_IDLE: fire_start = any_pending;
            ST_FIRE: begin
                if (t_done) begin
                    state_nxt = ST_GAP;
                    t_load    = 1'b1;
                    t_value   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (t_done) begin
                    if (any_pending)
                        fire_start = 1'b1;
                    else
                        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (fire_start) begin
            state_nxt = ST_FIRE;
            t_load    = 1'b1;
            t_value   = PULSE_LOAD;
        end
    end

    // The selected counter is consumed at the same edge the actuation starts.
    assign can_upd    = sat_update(can_cnt,    {1'b0, DISPENSE},        fire_start && (pick == SEL_CAN));
    assign nickel_upd = sat_update(nickel_cnt, {1'b0, NICKEL_OUT},      fire_start && (pick == SEL_NICKEL));
    assign dime_upd   = sat_update(dime_cnt,   {TWO_DIME_OUT, DIME_OUT}, fire_start && (pick == SEL_DIME));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            can_cnt    <= 2'd0;
            nickel_cnt <= 2'd0;
            dime_cnt   <= 2'd0;
            CAN_SOL    <= 1'b0;
            NICKEL_SOL <= 1'b0;
            DIME_SOL   <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            state      <= state_nxt;
            can_cnt    <= can_upd[1:0];
            nickel_cnt <= nickel_upd[1:0];
            dime_cnt   <= dime_upd[1:0];
            OVERRUN    <= OVERRUN | can_upd[2] | nickel_upd[2] | dime_upd[2];
            if (fire_start) begin
                CAN_SOL    <= (pick == SEL_CAN);
                NICKEL_SOL <= (pick == SEL_NICKEL);
                DIME_SOL   <= (pick == SEL_DIME);
            end else if (state_nxt != ST_FIRE) begin
                CAN_SOL    <= 1'b0;
                NICKEL_SOL <= 1'b0;
                DIME_SOL   <= 1'b0;
            end
        end
    end

    assign BUSY = (state != ST_IDLE) || any_pending;

endmodule

// File: tb/tb_dkm_eject.sv
// tb/tb_dkm_eject.sv - directed bench with slot-based reference model for dkm_eject
module tb_dkm_eject;

    localparam int P = 4;
    localparam int G = 2;

    logic CLK, RST, DISPENSE, NICKEL_OUT, DIME_OUT, TWO_DIME_OUT;
    logic CAN_SOL, NICKEL_SOL, DIME_SOL, BUSY, OVERRUN;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    dkm_eject #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .DISPENSE     (DISPENSE),
        .NICKEL_OUT   (NICKEL_OUT),
        .DIME_OUT     (DIME_OUT),
        .TWO_DIME_OUT (TWO_DIME_OUT),
        .CAN_SOL      (CAN_SOL),
        .NICKEL_SOL   (NICKEL_SOL),
        .DIME_SOL     (DIME_SOL),
        .BUSY         (BUSY),
        .OVERRUN      (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each actuation occupies a slot of P+G cycles; solenoid on while more than G remain.
    int m_cnt[3], m_cnt_n[3];
    int m_rem, m_rem_n, m_sel, m_sel_n;
    logic m_ovr, m_ovr_n;
    int mc_inc[3];
    int mc_dec, mc_v;

    always_comb begin
        m_cnt_n   = m_cnt;
        m_rem_n   = m_rem;
        m_sel_n   = m_sel;
        m_ovr_n   = m_ovr;
        mc_dec    = -1;
        mc_v      = 0;
        mc_inc[0] = int'(DISPENSE);
        mc_inc[1] = int'(NICKEL_OUT);
        mc_inc[2] = int'(DIME_OUT) + 2 * int'(TWO_DIME_OUT);
        if (m_rem > 1) begin
            m_rem_n = m_rem - 1;
        end else begin
            m_rem_n = 0;
            for (int i = 2; i >= 0; i--)
                if (m_cnt[i] > 0) mc_dec = i;
            if (mc_dec >= 0) begin
                m_rem_n = P + G;
                m_sel_n = mc_dec;
            end
        end
        for (int i = 0; i < 3; i++) begin
            mc_v = m_cnt[i] + mc_inc[i] - ((mc_dec == i) ? 1 : 0);
            if (mc_v > 3) begin
                mc_v    = 3;
                m_ovr_n = 1'b1;
            end
            m_cnt_n[i] = mc_v;
        end
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_cnt <= '{0, 0, 0};
            m_rem <= 0;
            m_sel <= 0;
            m_ovr <= 1'b0;
        end else begin
            m_cnt <= m_cnt_n;
            m_rem <= m_rem_n;
            m_sel <= m_sel_n;
            m_ovr <= m_ovr_n;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_can",    int'(CAN_SOL),    int'(m_rem > G && m_sel == 0));
            check("model_nickel", int'(NICKEL_SOL), int'(m_rem > G && m_sel == 1));
            check("model_dime",   int'(DIME_SOL),   int'(m_rem > G && m_sel == 2));
            check("model_busy",   int'(BUSY),       int'(m_rem != 0 || (m_cnt[0] + m_cnt[1] + m_cnt[2]) > 0));
            check("model_overrun", int'(OVERRUN),   int'(m_ovr));
        end
    end

    // Called at a negedge; the following rising edge samples the request (E0).
    task automatic req(input logic d, input logic n, input logic di, input logic t);
        DISPENSE = d; NICKEL_OUT = n; DIME_OUT = di; TWO_DIME_OUT = t;
        @(negedge CLK);
        DISPENSE = 1'b0; NICKEL_OUT = 1'b0; DIME_OUT = 1'b0; TWO_DIME_OUT = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic count_dime(input int cycles, output int pulses);
        logic prev;
        pulses = 0;
        prev = DIME_SOL;
        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK);
            if (DIME_SOL && !prev) pulses++;
            prev = DIME_SOL;
        end
    endtask

    int s, off, n_pulses;
    logic on;

    initial begin
        RST = 1'b0;
        DISPENSE = 1'b0; NICKEL_OUT = 1'b0; DIME_OUT = 1'b0; TWO_DIME_OUT = 1'b0;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("rst_can", int'(CAN_SOL), 0);
        check("rst_nickel", int'(NICKEL_SOL), 0);
        check("rst_dime", int'(DIME_SOL), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_overrun", int'(OVERRUN), 0);
        RST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check("idle_busy", int'(BUSY), 0);
        end

        // Single can
        req(1, 0, 0, 0);
        check("can_busy_e0", int'(BUSY), 1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            check("can_sol", int'(CAN_SOL), int'(k <= 4));
            check("can_busy", int'(BUSY), int'(k < 7));
        end

        // Can, nickel, dime together
        req(1, 1, 1, 0);
        for (int k = 1; k <= 19; k++) begin
            @(negedge CLK);
            s   = (k - 1) / 6;
            off = (k - 1) % 6;
            on  = (k <= 18) && (off < 4);
            check("all3_can", int'(CAN_SOL), int'(on && s == 0));
            check("all3_nickel", int'(NICKEL_SOL), int'(on && s == 1));
            check("all3_dime", int'(DIME_SOL), int'(on && s == 2));
            check("all3_busy", int'(BUSY), int'(k <= 18));
        end

        // Two dimes
        req(0, 0, 0, 1);
        for (int k = 1; k <= 13; k++) begin
            @(negedge CLK);
            check("two_dime_sol", int'(DIME_SOL), int'((k >= 1 && k <= 4) || (k >= 7 && k <= 10)));
            check("two_dime_can", int'(CAN_SOL | NICKEL_SOL), 0);
        end
        check("two_dime_busy_end", int'(BUSY), 0);

        // Nickel requested during the can gap follows straight after it
        req(1, 0, 0, 0);
        repeat (5) @(negedge CLK);
        req(0, 1, 0, 0);
        @(negedge CLK);
        check("gap_req_nickel", int'(NICKEL_SOL), 1);
        repeat (8) @(negedge CLK);
        check("gap_req_idle", int'(BUSY), 0);

        // Dime plus two-dime in one cycle: three pulses, no overrun
        req(0, 0, 1, 1);
        count_dime(25, n_pulses);
        check("dime3_pulses", n_pulses, 3);
        check("dime3_overrun", int'(OVERRUN), 0);

        // Overrun: four dime requests during can FIRE
        req(1, 0, 0, 0);
        DIME_OUT = 1'b1;
        repeat (4) @(negedge CLK);
        DIME_OUT = 1'b0;
        check("ovr_flag", int'(OVERRUN), 1);
        count_dime(40, n_pulses);
        check("ovr_pulses", n_pulses, 3);
        check("ovr_sticky", int'(OVERRUN), 1);
        check("ovr_busy_end", int'(BUSY), 0);

        do_reset();
        check("rst2_overrun", int'(OVERRUN), 0);

        // Reset in the second can cycle abandons the actuation
        req(1, 0, 0, 0);
        @(negedge CLK);
        check("midrst_can_on", int'(CAN_SOL), 1);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("midrst_can_off", int'(CAN_SOL), 0);
        check("midrst_busy", int'(BUSY), 0);
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check("post_rst_sol", int'(CAN_SOL | NICKEL_SOL | DIME_SOL), 0);
            check("post_rst_busy", int'(BUSY), 0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
